accumulator_cpu_gen2: RTL and testbench
=======================================

# accumulator_cpu_gen2

Parametrised second-generation accumulator processor: single accumulator, `DATA_W`-bit datapath, `2**ADDR_W`-word on-chip instruction memory loaded through a write port, and a start/halt run controller. Adds Z/C flags, logic, shift, conditional jumps and illegal-opcode trapping to the LOAD/ADD/SUB/HALT baseline. It is the CPU core instantiated by the system top; instruction memory is loaded by the host/bench before `start`.

## Interface
- `DATA_W`, 8: accumulator and immediate width; must satisfy `DATA_W >= ADDR_W`.
- `ADDR_W`, 4: PC / instruction-address width; memory depth is `2**ADDR_W`.
- `INSTR_W`, `4+DATA_W`: derived, not overridable. Layout: `[INSTR_W-1:DATA_W]` opcode, `[DATA_W-1:0]` operand.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `we` in 1: instruction-memory write enable.
- `instr_addr` in `ADDR_W`: write address.
- `instr_in` in `INSTR_W`: write data.
- `start` in 1: begin execution from address 0.
- `AC` out `DATA_W`: accumulator.
- `PC` out `ADDR_W`: program counter.
- `zf` out 1: zero flag.
- `cf` out 1: carry/borrow flag.
- `busy` out 1: high in FETCH or EXEC.
- `halted` out 1: high in HALTED.
- `err` out 1: illegal opcode trapped; sticky until `start` or reset.

## Operation
- Opcodes: 0000 NOP; 0001 LOAD imm; 0010 ADD; 0011 SUB; 0100 AND; 0101 OR; 0110 XOR; 0111 NOT (operand ignored); 1000 JMP; 1001 JZ; 1010 HALT; 1011 JC; 1100 SHL by operand[2:0]; 1101 SHR (logical) by operand[2:0]; 1110/1111 illegal.
- ADD: `{cf,AC} <= AC+imm`. SUB: `AC <= AC-imm` mod 2^DATA_W, `cf <= (AC < imm)`. SHL: `cf` = last bit shifted out, unchanged for shift 0. Logic ops and LOAD clear `cf`.
- `zf <= (new AC == 0)` on every AC-writing op. NOP, jumps, HALT leave AC and flags unchanged.
- Jump target = `operand[ADDR_W-1:0]`. JZ/JC taken if flag set, otherwise `PC+1`.
- PC increments modulo `2**ADDR_W`; `2**ADDR_W-1` wraps to 0 without halting.
- Illegal opcode: `err<=1`, enter HALTED, PC holds the faulting address.
- FSM: IDLE, FETCH, EXEC, HALTED.
  - IDLE/HALTED + `start` -> FETCH; PC, AC, `zf`, `cf`, `err` cleared.
  - FETCH -> EXEC: `IR <= mem[PC]` (synchronous read).
  - EXEC -> FETCH, or HALTED on HALT/illegal. PC holds the HALT address.
- Memory writes accepted only in IDLE/HALTED; `we` ignored while `busy`. Same-edge `we` and `start`: the write commits, and the first FETCH sees the new data.
- Memory is not reset.

## Timing
- Reset values: `AC=0`, `PC=0`, `zf=0`, `cf=0`, `busy=0`, `halted=0`, `err=0`, state IDLE. Reset asserted mid-run aborts immediately; memory contents are preserved.
- `start` sampled at edge k. Instruction i's AC, flags and PC results are visible after edge `k+2+2i`; CPI is 2.
- `halted` rises after the EXEC edge of HALT. `busy` falls on that same edge.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Package `acc_cpu_pkg`: opcode localparams, FSM state enum, and field-extract helpers for opcode/operand.
- Sub-module `acc_alu`: combinational, parametrised by `DATA_W`. Inputs: opcode, AC, operand. Outputs: result, `cf_next`, `zf_next`, write-enable. The top holds memory, IR, FSM, PC and registers.

## Test plan
- Default params. Program LOAD 3, ADD 5, SUB 2, HALT; `start` -> AC=6, `zf=0`, `cf=0`, `halted=1`, PC=3, `halted` rises 8 cycles after the start edge.
- LOAD 0xFF, ADD 1, JC 4, HALT@3, HALT@4 -> AC=0, `zf=1`, `cf=1`, PC=4. Then SUB 1 from a fresh LOAD 0 -> AC=0xFF, `cf=1`.
- Countdown: LOAD 3; SUB 1; JZ 4; JMP 1; HALT -> AC=0, `halted`, exactly 3 SUB executions.
- Opcode 1110 at address 2 -> `err=1`, `halted=1`, PC=2, AC unchanged. `we` pulse while `busy` -> memory readback unchanged.
- Reset pulse mid-loop -> all outputs 0 asynchronously. Re-`start` without reloading runs the same program to the same result.
- `DATA_W=16`, `ADDR_W=6`: LOAD 0x1234, ADD 0xF000, HALT -> AC=0x0234, `cf=1`. Also 64 NOPs with no HALT -> PC wraps from 63 to 0.

Source files
------------

// File: rtl/accumulator_cpu_gen2_pkg.sv
// Shared definitions for the gen2 accumulator CPU: opcodes, FSM states and
// instruction field helpers.
package acc_cpu_pkg;

    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned MAX_INSTR_W = 64;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED
    } state_e;

    // Callers zero-extend the instruction to MAX_INSTR_W and pass their DATA_W.
    function automatic logic [3:0] instr_opcode(input logic [MAX_INSTR_W-1:0] instr,
                                                input int unsigned data_w);
        return 4'(instr >> data_w);
    endfunction

    function automatic logic [MAX_INSTR_W-1:0] instr_operand(input logic [MAX_INSTR_W-1:0] instr,
                                                             input int unsigned data_w);
        return instr & ~({MAX_INSTR_W{1'b1}} << data_w);
    endfunction

    function automatic logic is_illegal(input logic [3:0] opcode);
        return (opcode == 4'hE) || (opcode == 4'hF);
    endfunction

endpackage

// File: rtl/accumulator_cpu_gen2_if.sv
// Host-side bus of the CPU core: program load port, run control and
// architectural state outputs.
interface accumulator_cpu_gen2_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) ();
    localparam int unsigned INSTR_W = 4 + DATA_W;

    logic                we;
    logic [ADDR_W-1:0]   instr_addr;
    logic [INSTR_W-1:0]  instr_in;
    logic                start;
    logic [DATA_W-1:0]   AC;
    logic [ADDR_W-1:0]   PC;
    logic                zf;
    logic                cf;
    logic                busy;
    logic                halted;
    logic                err;

    modport master (
        output we, instr_addr, instr_in, start,
        input  AC, PC, zf, cf, busy, halted, err
    );

    modport slave (
        input  we, instr_addr, instr_in, start,
        output AC, PC, zf, cf, busy, halted, err
    );
endinterface

// File: rtl/accumulator_cpu_gen2_alu.sv
// Combinational datapath for every accumulator-writing opcode; non-writing
// opcodes deassert we_o so the core leaves AC and flags untouched.
module acc_alu
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [3:0]        opcode_i,
    input  logic [DATA_W-1:0] ac_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic              cf_i,
    output logic [DATA_W-1:0] result_o,
    output logic              cf_next_o,
    output logic              zf_next_o,
    output logic              we_o
);
    logic [DATA_W:0] wide;
    logic [2:0]      shamt;

    assign shamt     = operand_i[2:0];
    assign zf_next_o = (result_o == '0);

    always_comb begin
        result_o  = ac_i;
        cf_next_o = cf_i;
        we_o      = 1'b1;
        wide      = '0;
        case (opcode_i)
            OP_LOAD: begin
                result_o  = operand_i;
                cf_next_o = 1'b0;
            end
            OP_ADD: begin
                wide      = {1'b0, ac_i} + {1'b0, operand_i};
                result_o  = wide[DATA_W-1:0];
                cf_next_o = wide[DATA_W];
            end
            OP_SUB: begin
                result_o  = ac_i - operand_i;
                cf_next_o = (ac_i < operand_i);
            end
            OP_AND: begin
                result_o  = ac_i & operand_i;
                cf_next_o = 1'b0;
            end
            OP_OR: begin
                result_o  = ac_i | operand_i;
                cf_next_o = 1'b0;
            end
            OP_XOR: begin
                result_o  = ac_i ^ operand_i;
                cf_next_o = 1'b0;
            end
            OP_NOT: begin
                result_o  = ~ac_i;
                cf_next_o = 1'b0;
            end
            // One guard bit beside AC catches the last bit shifted out.
            OP_SHL: begin
                wide     = {1'b0, ac_i} << shamt;
                result_o = wide[DATA_W-1:0];
                if (shamt != 3'd0) cf_next_o = wide[DATA_W];
            end
            OP_SHR: begin
                wide     = {ac_i, 1'b0} >> shamt;
                result_o = wide[DATA_W:1];
                if (shamt != 3'd0) cf_next_o = wide[0];
            end
            default: we_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/accumulator_cpu_gen2.sv
// Gen2 accumulator CPU core: instruction memory, IR, PC, flags and the
// IDLE/FETCH/EXEC/HALTED run controller (two cycles per instruction).
module accumulator_cpu_gen2
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    accumulator_cpu_gen2_if.slave bus
);
    localparam int unsigned INSTR_W = OPCODE_W + DATA_W;
    localparam int unsigned DEPTH   = 2 ** ADDR_W;

    logic [INSTR_W-1:0] mem_q [DEPTH];

    state_e             state_q;
    logic [INSTR_W-1:0] ir_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [DATA_W-1:0]  ac_q;
    logic               zf_q;
    logic               cf_q;
    logic               err_q;
    logic               busy_q;
    logic               halted_q;

    logic [3:0]         opcode;
    logic [DATA_W-1:0]  operand;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  jmp_tgt;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_cf;
    logic               alu_zf;
    logic               alu_we;

    assign opcode  = instr_opcode(MAX_INSTR_W'(ir_q), DATA_W);
    assign operand = DATA_W'(instr_operand(MAX_INSTR_W'(ir_q), DATA_W));
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign jmp_tgt = operand[ADDR_W-1:0];

    acc_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode_i  (opcode),
        .ac_i      (ac_q),
        .operand_i (operand),
        .cf_i      (cf_q),
        .result_o  (alu_res),
        .cf_next_o (alu_cf),
        .zf_next_o (alu_zf),
        .we_o      (alu_we)
    );

    // Memory has no reset so a reset mid-run keeps the loaded program.
    always_ff @(posedge clk) begin
        if (bus.we && !busy_q) mem_q[bus.instr_addr] <= bus.instr_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            pc_q     <= '0;
            ac_q     <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q    <= mem_q[pc_q];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    if (is_illegal(opcode)) begin
                        err_q    <= 1'b1;
                        state_q  <= S_HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        case (opcode)
                            OP_HALT: begin
                                state_q  <= S_HALTED;
                                busy_q   <= 1'b0;
                                halted_q <= 1'b1;
                            end
                            OP_JMP:  pc_q <= jmp_tgt;
                            OP_JZ:   pc_q <= zf_q ? jmp_tgt : pc_inc;
                            OP_JC:   pc_q <= cf_q ? jmp_tgt : pc_inc;
                            default: begin
                                pc_q <= pc_inc;
                                if (alu_we) begin
                                    ac_q <= alu_res;
                                    zf_q <= alu_zf;
                                    cf_q <= alu_cf;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    if (bus.start) begin
                        state_q  <= S_FETCH;
                        pc_q     <= '0;
                        ac_q     <= '0;
                        zf_q     <= 1'b0;
                        cf_q     <= 1'b0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.AC     = ac_q;
    assign bus.PC     = pc_q;
    assign bus.zf     = zf_q;
    assign bus.cf     = cf_q;
    assign bus.busy   = busy_q;
    assign bus.halted = halted_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_accumulator_cpu_gen2.sv
// Scoreboard bench for accumulator_cpu_gen2: directed programs push their
// expected final state, and a monitor checks it when halted rises.
module tb_accumulator_cpu_gen2;

    typedef struct {
        string       name;
        logic [31:0] ac;
        logic [31:0] pc;
        logic        zf;
        logic        cf;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst1_n;
    logic rst2_n;
    always #5 clk = ~clk;

    accumulator_cpu_gen2_if #(.DATA_W(8),  .ADDR_W(4)) b1 ();
    accumulator_cpu_gen2_if #(.DATA_W(16), .ADDR_W(6)) b2 ();

    accumulator_cpu_gen2 #(.DATA_W(8), .ADDR_W(4)) u_dut1 (
        .clk     (clk),
        .reset_n (rst1_n),
        .bus     (b1.slave)
    );

    accumulator_cpu_gen2 #(.DATA_W(16), .ADDR_W(6)) u_dut2 (
        .clk     (clk),
        .reset_n (rst2_n),
        .bus     (b2.slave)
    );

    exp_t        q1[$];
    exp_t        q2[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          start1 = 0;
    int          start2 = 0;
    logic        h1_prev = 1'b0;
    logic        h2_prev = 1'b0;
    logic [11:0] p1[$];
    logic [19:0] p2[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input string name, input logic [31:0] ac, input logic [31:0] pc,
                                input logic zf, input logic cf, input logic err, input int lat);
        exp_t e;
        e.name = name; e.ac = ac; e.pc = pc; e.zf = zf; e.cf = cf; e.err = err; e.lat = lat;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic score(input exp_t e, input logic [31:0] ac, input logic [31:0] pc,
                         input logic zf, input logic cf, input logic err, input logic busy,
                         input int lat);
        chk({e.name, ".AC"},   ac,         e.ac);
        chk({e.name, ".PC"},   pc,         e.pc);
        chk({e.name, ".zf"},   32'(zf),    32'(e.zf));
        chk({e.name, ".cf"},   32'(cf),    32'(e.cf));
        chk({e.name, ".err"},  32'(err),   32'(e.err));
        chk({e.name, ".busy"}, 32'(busy),  32'd0);
        chk({e.name, ".lat"},  32'(lat),   32'(e.lat));
    endtask

    always @(negedge clk) begin
        if (b1.halted && !h1_prev) begin
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut1.unexpected_halt: got halted=1, expected no halt");
            end else begin
                score(q1.pop_front(), 32'(b1.AC), 32'(b1.PC), b1.zf, b1.cf, b1.err, b1.busy,
                      cyc - start1);
            end
        end
        h1_prev = b1.halted;
    end

    always @(negedge clk) begin
        if (b2.halted && !h2_prev) begin
            if (q2.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut2.unexpected_halt: got halted=1, expected no halt");
            end else begin
                score(q2.pop_front(), 32'(b2.AC), 32'(b2.PC), b2.zf, b2.cf, b2.err, b2.busy,
                      cyc - start2);
            end
        end
        h2_prev = b2.halted;
    end

    task automatic check_zero1(input string tag);
        chk({tag, ".AC"},     32'(b1.AC),     32'd0);
        chk({tag, ".PC"},     32'(b1.PC),     32'd0);
        chk({tag, ".zf"},     32'(b1.zf),     32'd0);
        chk({tag, ".cf"},     32'(b1.cf),     32'd0);
        chk({tag, ".busy"},   32'(b1.busy),   32'd0);
        chk({tag, ".halted"}, 32'(b1.halted), 32'd0);
        chk({tag, ".err"},    32'(b1.err),    32'd0);
    endtask

    task automatic wr1(input logic [3:0] a, input logic [11:0] d);
        @(negedge clk);
        b1.we = 1'b1; b1.instr_addr = a; b1.instr_in = d;
        @(posedge clk);
        #1 b1.we = 1'b0;
    endtask

    task automatic load1(input int base);
        for (int i = 0; i < p1.size(); i++) wr1(4'(base + i), p1[i]);
    endtask

    task automatic start1_pulse(input logic with_we, input logic [3:0] a, input logic [11:0] d);
        @(negedge clk);
        b1.start = 1'b1;
        b1.we = with_we; b1.instr_addr = a; b1.instr_in = d;
        @(posedge clk);
        #1 start1 = cyc;
        b1.start = 1'b0; b1.we = 1'b0;
    endtask

    task automatic wait1(input string tag);
        for (int i = 0; i < 300 && q1.size() != 0; i++) @(negedge clk);
        #1;
        if (q1.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s.timeout: got no halt, expected halt within 300 cycles", tag);
            q1.delete();
        end
    endtask

    task automatic run1(input exp_t e);
        q1.push_back(e);
        start1_pulse(1'b0, 4'd0, 12'd0);
        wait1(e.name);
    endtask

    task automatic wr2(input logic [5:0] a, input logic [19:0] d);
        @(negedge clk);
        b2.we = 1'b1; b2.instr_addr = a; b2.instr_in = d;
        @(posedge clk);
        #1 b2.we = 1'b0;
    endtask

    task automatic start2_pulse();
        @(negedge clk);
        b2.start = 1'b1;
        @(posedge clk);
        #1 start2 = cyc;
        b2.start = 1'b0;
    endtask

    task automatic run2(input exp_t e);
        q2.push_back(e);
        start2_pulse();
        for (int i = 0; i < 300 && q2.size() != 0; i++) @(negedge clk);
        #1;
        if (q2.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s.timeout: got no halt, expected halt within 300 cycles", e.name);
            q2.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst1_n = 1'b0; rst2_n = 1'b0;
        b1.we = 1'b0; b1.start = 1'b0; b1.instr_addr = '0; b1.instr_in = '0;
        b2.we = 1'b0; b2.start = 1'b0; b2.instr_addr = '0; b2.instr_in = '0;
        repeat (3) @(posedge clk);
        #1 check_zero1("reset");
        chk("reset2.PC", 32'(b2.PC), 32'd0);
        @(negedge clk);
        rst1_n = 1'b1; rst2_n = 1'b1;

        p1 = '{12'h103, 12'h205, 12'h302, 12'hA00};
        load1(0);
        run1(mk("progA", 32'h06, 32'd3, 1'b0, 1'b0, 1'b0, 8));

        p1 = '{12'h1FF, 12'h201, 12'hB04, 12'hA00, 12'hA00};
        load1(0);
        run1(mk("progB", 32'h00, 32'd4, 1'b1, 1'b1, 1'b0, 8));

        // address 0 is rewritten on the very edge that samples start
        p1 = '{12'h301, 12'hA00};
        load1(1);
        q1.push_back(mk("subBorrow", 32'hFF, 32'd2, 1'b0, 1'b1, 1'b0, 6));
        start1_pulse(1'b1, 4'd0, 12'h100);
        wait1("subBorrow");

        p1 = '{12'h1C5, 12'h40F, 12'h530, 12'h6FF, 12'h700, 12'hC03, 12'hD04, 12'hC00, 12'hA00};
        load1(0);
        run1(mk("logicShift", 32'h0A, 32'd8, 1'b0, 1'b1, 1'b0, 18));

        p1 = '{12'h15A, 12'h000, 12'hE00};
        load1(0);
        q1.push_back(mk("illegal", 32'h5A, 32'd2, 1'b0, 1'b0, 1'b1, 6));
        start1_pulse(1'b0, 4'd0, 12'd0);
        wr1(4'd0, 12'h177);
        wait1("illegal");
        run1(mk("illegalRerun", 32'h5A, 32'd2, 1'b0, 1'b0, 1'b1, 6));

        p1 = '{12'h103, 12'h301, 12'h904, 12'h801, 12'hA00};
        load1(0);
        run1(mk("countdown", 32'h00, 32'd4, 1'b1, 1'b0, 1'b0, 20));

        start1_pulse(1'b0, 4'd0, 12'd0);
        repeat (7) @(posedge clk);
        #2 rst1_n = 1'b0;
        #1 check_zero1("midReset");
        repeat (2) @(negedge clk);
        rst1_n = 1'b1;
        run1(mk("countdownAfterReset", 32'h00, 32'd4, 1'b1, 1'b0, 1'b0, 20));

        p2 = '{20'h11234, 20'h2F000, 20'hA0000};
        for (int i = 0; i < p2.size(); i++) wr2(6'(i), p2[i]);
        run2(mk("wide", 32'h0234, 32'd2, 1'b0, 1'b1, 1'b0, 6));

        for (int i = 0; i < 64; i++) wr2(6'(i), 20'h00000);
        start2_pulse();
        for (int i = 0; i < 300 && b2.PC != 6'd63; i++) @(negedge clk);
        chk("wrap.reach63", 32'(b2.PC), 32'd63);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("wrap.PC",     32'(b2.PC),     32'd0);
        chk("wrap.busy",   32'(b2.busy),   32'd1);
        chk("wrap.halted", 32'(b2.halted), 32'd0);
        rst2_n = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
